pdemux_1_to_16_reg: RTL and testbench
=====================================

// Module: pdemux_1_to_16_reg
// PURPOSE
//  Registered 1:16 demultiplexer (write side of a 16-entry select path): one width-bit input is
//  steered into one of 16 held output registers chosen by a 4-bit select, complementing the 16:1
//  read muxes that consume out1..out16. A sequential fill engine can sweep one value into all 16
//  registers, one per cycle. Sits between the ALU result bus and the register/operand selection muxes.
// PARAMETERS
//  width  8  bit width of D, fill_val and every outN
// PORTS
//  clk         input   1      single clock; all state updates on posedge clk
//  rst         input   1      synchronous, active-high reset
//  D           input   width  write data
//  S           input   4      write select: 0 -> out1 ... 15 -> out16
//  we          input   1      write enable; accepted only when wr_ready=1
//  wr_ready    output  1      combinational: 1 when state=IDLE
//  fill_req    input   1      start fill sweep; sampled only in IDLE
//  fill_val    input   width  fill value, captured on the accepting edge
//  busy        output  1      registered: 1 while state=SWEEP
//  fill_done   output  1      registered single-cycle pulse after the 16th sweep write
//  wr_strobe   output  16     registered one-hot of the index written on the previous edge (0 if none)
//  out1..out16 output  width  each: held output register
// BEHAVIOUR
//  - Reset (rst=1 at an edge): out1..out16=0, wr_strobe=0, busy=0, fill_done=0, cnt=0, fill_q=0, state=IDLE.
//    rst overrides everything, including mid-sweep; sweep is abandoned with no fill_done.
//  - IDLE, we=1: at the edge, out[S+1] <= D; the other 15 hold. Latency 1 cycle; wr_strobe[S]=1 for one cycle.
//  - IDLE, fill_req=1: at the edge, fill_q <= fill_val, cnt <= 0, state -> SWEEP.
//  - IDLE, we and fill_req together: both accepted. The write lands on that edge; the sweep
//    overwrites that index later.
//  - SWEEP: each edge out[cnt+1] <= fill_q, wr_strobe = onehot(cnt), cnt <= cnt+1 (4-bit).
//    - When cnt=15 is written, state -> IDLE and fill_done=1 for the next cycle.
//    - The sweep is exactly 16 cycles; busy is high for exactly those 16 cycles.
//  - SWEEP: we and fill_req are ignored and dropped (wr_ready=0); no queuing.
//  - fill_req in the cycle after fill_done (state=IDLE again) starts a new sweep normally.
//  - No arithmetic on data; cnt wraps 15->0 only at the SWEEP exit.
//  - S is always a valid 4-bit value; there is no out-of-range case.
//  - FSM states: IDLE (wr_ready=1), SWEEP (busy=1). Transitions:
//    IDLE -fill_req-> SWEEP
//    SWEEP -cnt==15-> IDLE
//    any -rst-> IDLE
// STRUCTURE
//  - Shared package: SEL_W=4, NUM_PORTS=16, FSM state encodings (IDLE=1'b0, SWEEP=1'b1).
//  - Sub-module param_4_to_16_decoder (S, en -> 16-bit one-hot). Instantiated once.
//    - Its en = (we&wr_ready) | busy.
//    - Its select input is muxed between S and cnt.
//  - Write data per register = busy ? fill_q : D. One 16-way register array, 16 registered outputs.
// TESTING  (width=8)
//  1. rst=1 for 2 cycles -> all outN=8'h00, busy=0, wr_ready=1, wr_strobe=0.
//  2. we=1, S=4'h0, D=8'hA5; then S=4'hF, D=8'h3C
//     -> out1=A5 and out16=3C, each after 1 edge; others 00; wr_strobe=0001 then 8000.
//  3. fill_req=1, fill_val=8'h5A -> busy=1 for exactly 16 cycles; wr_strobe walks 0001..8000;
//     all outN=5A; fill_done pulses once in cycle 17; wr_ready returns to 1.
//  4. Mid-sweep (cycle 5): we=1, S=4'h2, D=8'hFF -> dropped; out3=5A at the end.
//     A second fill_req mid-sweep is ignored (single fill_done).
//  5. Same cycle in IDLE: we=1, S=4'h7, D=8'h11 with fill_req=1, fill_val=8'h22
//     -> out8=11 after edge 1, becomes 22 on sweep cycle 8; final all 22.
//  6. rst=1 asserted at sweep cycle 9 -> next edge all outN=00, busy=0, no fill_done;
//     a new fill_req afterwards sweeps from out1.

Source files
------------

// File: rtl/pdemux_1_to_16_reg_pkg.sv
// Shared definitions for the registered 1:16 demultiplexer.
//   SEL_W     : select / sweep counter width
//   NUM_PORTS : number of held output registers
//   LAST_IDX  : index written on the final sweep cycle
//   state_t   : controller states
package pdemux_1_to_16_reg_pkg;

  localparam int SEL_W     = 4;
  localparam int NUM_PORTS = 16;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/pdemux_1_to_16_reg_if.sv
// Write-side bus of the 1:16 demultiplexer.
//   master : drives D, S, we, fill_req, fill_val; observes wr_ready, busy, fill_done, wr_strobe
//   slave  : the demultiplexer itself
interface pdemux_1_to_16_reg_if
  import pdemux_1_to_16_reg_pkg::*;
#(
  parameter int width = 8
);

  logic [width-1:0]     D;
  logic [SEL_W-1:0]     S;
  logic                 we;
  logic                 wr_ready;
  logic                 fill_req;
  logic [width-1:0]     fill_val;
  logic                 busy;
  logic                 fill_done;
  logic [NUM_PORTS-1:0] wr_strobe;

  modport master (
    output D, S, we, fill_req, fill_val,
    input  wr_ready, busy, fill_done, wr_strobe
  );

  modport slave (
    input  D, S, we, fill_req, fill_val,
    output wr_ready, busy, fill_done, wr_strobe
  );

endinterface

// File: rtl/pdemux_1_to_16_reg_decoder.sv
// 4-to-16 one-hot decoder with enable.
//   sel    : index to decode
//   en     : when low the output is all zeros
//   onehot : one-hot of sel
module param_4_to_16_decoder
  import pdemux_1_to_16_reg_pkg::*;
(
  input  logic [SEL_W-1:0]     sel,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/pdemux_1_to_16_reg.sv
// Registered 1:16 demultiplexer with a sequential fill engine.
//   clk, rst     : clock and synchronous active-high reset
//   bus (slave)  : write data/select/enable, fill request/value, ready/busy/done/strobe status
//   out1..out16  : held output registers
//
// state | meaning
// IDLE  | accepts single writes and fill requests (wr_ready=1)
// SWEEP | writes fill_q into out[cnt+1] each cycle, ignores bus requests (busy=1)
module pdemux_1_to_16_reg
  import pdemux_1_to_16_reg_pkg::*;
#(
  parameter int width = 8
)(
  input  logic                         clk,
  input  logic                         rst,
  pdemux_1_to_16_reg_if.slave          bus,
  output logic [width-1:0]             out1,
  output logic [width-1:0]             out2,
  output logic [width-1:0]             out3,
  output logic [width-1:0]             out4,
  output logic [width-1:0]             out5,
  output logic [width-1:0]             out6,
  output logic [width-1:0]             out7,
  output logic [width-1:0]             out8,
  output logic [width-1:0]             out9,
  output logic [width-1:0]             out10,
  output logic [width-1:0]             out11,
  output logic [width-1:0]             out12,
  output logic [width-1:0]             out13,
  output logic [width-1:0]             out14,
  output logic [width-1:0]             out15,
  output logic [width-1:0]             out16
);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     cnt_q;
  logic [width-1:0]     fill_q;
  logic [width-1:0]     regs [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_strobe_q;
  logic                 fill_done_q;

  logic                 dec_en;
  logic [SEL_W-1:0]     dec_sel;
  logic [width-1:0]     wr_data;
  logic [NUM_PORTS-1:0] wr_sel;

  // Decoder enable is (we & wr_ready) | busy; select and data follow the
  // sweep counter while sweeping, the bus otherwise.
  always_comb begin
    state_d = state_q;
    dec_en  = 1'b0;
    dec_sel = bus.S;
    wr_data = bus.D;
    case (state_q)
      IDLE: begin
        dec_en = bus.we;
        if (bus.fill_req) state_d = SWEEP;
      end
      SWEEP: begin
        dec_en  = 1'b1;
        dec_sel = cnt_q;
        wr_data = fill_q;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  param_4_to_16_decoder u_dec (
    .sel    (dec_sel),
    .en     (dec_en),
    .onehot (wr_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      wr_strobe_q <= '0;
      fill_done_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) regs[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_strobe_q <= wr_sel;
      fill_done_q <= (state_q == SWEEP) && (cnt_q == LAST_IDX);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
      if (state_q == IDLE && bus.fill_req) begin
        fill_q <= bus.fill_val;
        cnt_q  <= '0;
      end else if (state_q == SWEEP) begin
        cnt_q  <= cnt_q + 1'b1;  // wraps to 0 on the exit cycle
      end
    end
  end

  // busy and wr_ready are taken straight from the state flop.
  assign bus.wr_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SWEEP);
  assign bus.fill_done = fill_done_q;
  assign bus.wr_strobe = wr_strobe_q;

  assign out1  = regs[0];
  assign out2  = regs[1];
  assign out3  = regs[2];
  assign out4  = regs[3];
  assign out5  = regs[4];
  assign out6  = regs[5];
  assign out7  = regs[6];
  assign out8  = regs[7];
  assign out9  = regs[8];
  assign out10 = regs[9];
  assign out11 = regs[10];
  assign out12 = regs[11];
  assign out13 = regs[12];
  assign out14 = regs[13];
  assign out15 = regs[14];
  assign out16 = regs[15];

endmodule

// File: tb/tb_pdemux_1_to_16_reg.sv
// Self-checking bench for pdemux_1_to_16_reg (width=8): directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_pdemux_1_to_16_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdemux_1_to_16_reg_if #(.width(8)) bus ();

  wire [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15, o16;
  logic [7:0] dout [16];

  pdemux_1_to_16_reg #(.width(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .out1(o1), .out2(o2), .out3(o3), .out4(o4), .out5(o5), .out6(o6), .out7(o7), .out8(o8),
    .out9(o9), .out10(o10), .out11(o11), .out12(o12), .out13(o13), .out14(o14), .out15(o15),
    .out16(o16)
  );

  always_comb begin
    dout[0] = o1;   dout[1] = o2;   dout[2] = o3;   dout[3] = o4;
    dout[4] = o5;   dout[5] = o6;   dout[6] = o7;   dout[7] = o8;
    dout[8] = o9;   dout[9] = o10;  dout[10] = o11; dout[11] = o12;
    dout[12] = o13; dout[13] = o14; dout[14] = o15; dout[15] = o16;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining sweep writes and the array of held values.
  logic [7:0]  m_out [16];
  logic [7:0]  m_fill;
  int          sweep_rem;
  logic [15:0] e_strobe;
  logic        e_done;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_out[i] = 8'h00;
      m_fill = 8'h00; sweep_rem = 0; e_strobe = 16'h0; e_done = 1'b0;
    end else begin
      e_strobe = 16'h0;
      e_done   = 1'b0;
      if (sweep_rem > 0) begin
        int idx;
        idx = 16 - sweep_rem;
        m_out[idx] = m_fill;
        e_strobe = 16'h1 << idx;
        sweep_rem--;
        if (sweep_rem == 0) e_done = 1'b1;
      end else begin
        if (bus.we) begin
          m_out[bus.S] = bus.D;
          e_strobe = 16'h1 << bus.S;
        end
        if (bus.fill_req) begin
          m_fill = bus.fill_val;
          sweep_rem = 16;
        end
      end
    end
  end

  // Per-cycle compare plus running counts of busy cycles and fill_done pulses.
  logic check_en = 1'b0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", bus.busy, sweep_rem > 0);
      chk("wr_ready", bus.wr_ready, sweep_rem == 0);
      chk("fill_done", bus.fill_done, e_done);
      chk("wr_strobe", bus.wr_strobe, e_strobe);
      for (int i = 0; i < 16; i++) chk($sformatf("out%0d", i + 1), dout[i], m_out[i]);
      if (bus.busy) busy_cnt++;
      if (bus.fill_done) done_cnt++;
    end
  end

  task automatic clr_req();
    bus.we = 1'b0; bus.fill_req = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 40 && !bus.wr_ready; i++) @(negedge clk);
    chk({nm, "_ready_timeout"}, bus.wr_ready, 1'b1);
  endtask

  task automatic chk_all(input string nm, input logic [7:0] v);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_dut_out%0d", nm, i + 1), dout[i], v);
      chk($sformatf("%s_model_out%0d", nm, i + 1), m_out[i], v);
    end
  endtask

  int b0, d0;

  initial begin
    rst = 1'b1;
    bus.we = 1'b0; bus.S = 4'h0; bus.D = 8'h00;
    bus.fill_req = 1'b0; bus.fill_val = 8'h00;

    // 1. reset
    @(negedge clk); @(negedge clk);
    check_en = 1'b1;
    chk_all("reset", 8'h00);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ready", bus.wr_ready, 1'b1);
    chk("reset_strobe", bus.wr_strobe, 16'h0000);
    rst = 1'b0;

    // 2. single writes to both ends
    bus.we = 1'b1; bus.S = 4'h0; bus.D = 8'hA5;
    @(negedge clk);
    chk("w1_out1", o1, 8'hA5);
    chk("w1_strobe", bus.wr_strobe, 16'h0001);
    bus.S = 4'hF; bus.D = 8'h3C;
    @(negedge clk);
    clr_req();
    chk("w2_out16", o16, 8'h3C);
    chk("w2_out1", o1, 8'hA5);
    chk("w2_out2", o2, 8'h00);
    chk("w2_strobe", bus.wr_strobe, 16'h8000);

    // 3/4. fill sweep with a dropped write and dropped fill_req mid-sweep
    b0 = busy_cnt; d0 = done_cnt;
    bus.fill_req = 1'b1; bus.fill_val = 8'h5A;
    @(negedge clk);
    clr_req();
    repeat (4) @(negedge clk);
    bus.we = 1'b1; bus.S = 4'h2; bus.D = 8'hFF;
    bus.fill_req = 1'b1; bus.fill_val = 8'h77;
    @(negedge clk);
    clr_req();
    wait_ready("fill5a");
    chk("fill5a_done", bus.fill_done, 1'b1);
    chk("fill5a_last_strobe", bus.wr_strobe, 16'h8000);
    @(negedge clk);
    chk("fill5a_busy_cycles", busy_cnt - b0, 16);
    chk("fill5a_done_pulses", done_cnt - d0, 1);
    chk_all("fill5a", 8'h5A);

    // 5. simultaneous write and fill, then back-to-back fill after fill_done
    bus.we = 1'b1; bus.S = 4'h7; bus.D = 8'h11;
    bus.fill_req = 1'b1; bus.fill_val = 8'h22;
    @(negedge clk);
    clr_req();
    chk("both_out8", o8, 8'h11);
    repeat (7) @(negedge clk);
    chk("both_out8_before", o8, 8'h11);
    @(negedge clk);
    chk("both_out8_after", o8, 8'h22);
    wait_ready("fill22");
    chk("fill22_done", bus.fill_done, 1'b1);
    chk_all("fill22", 8'h22);
    bus.fill_req = 1'b1; bus.fill_val = 8'h33;
    @(negedge clk);
    clr_req();
    chk("b2b_busy", bus.busy, 1'b1);
    wait_ready("fill33");
    @(negedge clk);
    chk_all("fill33", 8'h33);

    // 6. reset mid-sweep, then a fresh sweep starts from out1
    d0 = done_cnt;
    bus.fill_req = 1'b1; bus.fill_val = 8'h44;
    @(negedge clk);
    clr_req();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all("midrst", 8'h00);
    chk("midrst_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    bus.fill_req = 1'b1; bus.fill_val = 8'h66;
    @(negedge clk);
    clr_req();
    chk("refill_strobe0", bus.wr_strobe, 16'h0000);
    @(negedge clk);
    chk("refill_strobe1", bus.wr_strobe, 16'h0001);
    chk("refill_out1", o1, 8'h66);
    chk("refill_out2", o2, 8'h00);
    wait_ready("fill66");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.we       = ($urandom_range(0, 99) < 35);
      bus.fill_req = ($urandom_range(0, 99) < 4);
      bus.S        = 4'($urandom);
      bus.D        = 8'($urandom);
      bus.fill_val = 8'($urandom);
      rst          = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    clr_req();
    @(negedge clk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
